// File: rtl/shm_i2c_arbiter.sv
// Round-robin arbiter sharing one I2C_CONTROLLER between NUM_REQ write requesters.
// Latches the winner's command, tracks the busy handshake and returns done/fail.
module shm_i2c_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int REPEAT_SZ     = 6,
  parameter int START_TIMEOUT = 255,
  localparam int OW           = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [8*NUM_REQ-1:0]          req_location,
  input  logic [8*NUM_REQ-1:0]          req_data,
  input  logic [REPEAT_SZ*NUM_REQ-1:0]  req_repeat,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic                          fail,
  output logic [OW-1:0]                 owner,
  output logic                          idle,
  output logic                          activate,
  output logic [7:0]                    location,
  output logic [7:0]                    data,
  output logic [REPEAT_SZ-1:0]          data_repeat,
  input  logic                          busy,
  input  logic                          abort
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_COMPLETE
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        rr_q, rr_d;
  logic                 activate_q, activate_d;
  logic [7:0]           location_q, location_d;
  logic [7:0]           data_q, data_d;
  logic [REPEAT_SZ-1:0] repeat_q, repeat_d;
  logic [15:0]          timer_q, timer_d;
  logic                 abort_seen_q, abort_seen_d;
  logic                 fail_q, fail_d;

  logic [OW:0]          scan_idx [NUM_REQ];
  logic [7:0]           loc_arr  [NUM_REQ];
  logic [7:0]           data_arr [NUM_REQ];
  logic [REPEAT_SZ-1:0] rep_arr  [NUM_REQ];
  logic                 pick_found;
  logic [OW-1:0]        pick_idx;

  // scan_idx[k] = (rr + k) mod NUM_REQ, the k-th candidate in round-robin order
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
    logic [OW:0] sum;
    assign sum           = {1'b0, rr_q} + (OW+1)'(gi);
    assign scan_idx[gi]  = (sum >= (OW+1)'(NUM_REQ)) ? sum - (OW+1)'(NUM_REQ) : sum;
    assign loc_arr[gi]   = req_location[gi*8 +: 8];
    assign data_arr[gi]  = req_data[gi*8 +: 8];
    assign rep_arr[gi]   = req_repeat[gi*REPEAT_SZ +: REPEAT_SZ];
  end

  always_comb begin
    pick_found = |req;
    pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[scan_idx[k][OW-1:0]]) pick_idx = scan_idx[k][OW-1:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    activate_d   = activate_q;
    location_d   = location_q;
    data_d       = data_q;
    repeat_d     = repeat_q;
    timer_d      = timer_q;
    abort_seen_d = abort_seen_q;
    fail_d       = fail_q;
    case (state_q)
      S_IDLE: begin
        // a controller still busy from before reset must drain first
        if (!busy && pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          location_d        = loc_arr[pick_idx];
          data_d            = data_arr[pick_idx];
          repeat_d          = rep_arr[pick_idx];
          abort_seen_d      = 1'b0;
          fail_d            = 1'b0;
          state_d           = S_ISSUE;
        end
      end
      S_ISSUE: begin
        activate_d = 1'b1;
        timer_d    = 16'(START_TIMEOUT);
        state_d    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (busy) begin
          activate_d = 1'b0;
          state_d    = S_WAIT_DONE;
        end else if (timer_q == '0) begin
          activate_d = 1'b0;
          fail_d     = 1'b1;
          state_d    = S_COMPLETE;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_WAIT_DONE: begin
        abort_seen_d = abort_seen_q | abort;
        if (!busy) begin
          fail_d  = abort_seen_q | abort;
          state_d = S_COMPLETE;
        end
      end
      S_COMPLETE: begin
        grant_d = '0;
        rr_d    = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      rr_q         <= '0;
      activate_q   <= 1'b0;
      location_q   <= '0;
      data_q       <= '0;
      repeat_q     <= '0;
      timer_q      <= '0;
      abort_seen_q <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      rr_q         <= rr_d;
      activate_q   <= activate_d;
      location_q   <= location_d;
      data_q       <= data_d;
      repeat_q     <= repeat_d;
      timer_q      <= timer_d;
      abort_seen_q <= abort_seen_d;
      fail_q       <= fail_d;
    end
  end

  assign grant       = grant_q;
  assign done        = (state_q == S_COMPLETE) ? grant_q : '0;
  assign fail        = (state_q == S_COMPLETE) & fail_q;
  assign owner       = owner_q;
  assign idle        = (state_q == S_IDLE) & ~busy;
  assign activate    = activate_q;
  assign location    = location_q;
  assign data        = data_q;
  assign data_repeat = repeat_q;

endmodule
